// File: rtl/rcc_pkg.sv
// Shared RCC definitions: clock-monitor FSM states and the even-ratio rule
// used by both the clock divider and the ratio monitor.
package rcc_pkg;

    typedef enum logic [1:0] {IDLE, ARM, HIGH, LOW} mon_state_t;

    // Widest division ratio the shared helper accepts.
    localparam int unsigned RATIO_MAX_W = 16;

    // The divider cannot produce odd ratios with a 50% duty cycle, so 2k+1 runs as 2k.
    function automatic logic [RATIO_MAX_W-1:0] even_ratio(input logic [RATIO_MAX_W-1:0] ratio);
        return ratio & ~RATIO_MAX_W'(1);
    endfunction

endpackage

// File: rtl/sync_2ff.sv
// Generic two-flop synchronizer with asynchronous active-low reset.
module sync_2ff #(
    parameter int unsigned W = 1
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic [W-1:0] d,
    output logic [W-1:0] q
);

    logic [W-1:0] meta;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            meta <= '0;
            q    <= '0;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end

endmodule

// File: rtl/clk_ratio_monitor.sv
// Measures period and high time of the divided clock in REF_CLK cycles and flags
// ratio mismatch or a stuck/absent divided clock.
module clk_ratio_monitor
    import rcc_pkg::*;
#(
    parameter int unsigned WIDTH   = 6,
    parameter int unsigned CNT_W   = 8,
    parameter int unsigned TIMEOUT = 200
) (
    input  logic             REF_CLK,
    input  logic             RST,
    input  logic             MON_CLK,
    input  logic [WIDTH-1:0] EXP_RATIO,
    input  logic             MEAS_EN,
    input  logic             CLR,
    output logic [CNT_W-1:0] PERIOD,
    output logic [CNT_W-1:0] HIGH_TIME,
    output logic             MEAS_VALID,
    output logic             MISMATCH,
    output logic             STUCK
);

    localparam logic [CNT_W-1:0] CNT_MAX   = {CNT_W{1'b1}};
    localparam logic [CNT_W-1:0] ONE       = CNT_W'(1);
    localparam logic [CNT_W-1:0] TIMEOUT_C = CNT_W'(TIMEOUT);

    logic             mon_sync;
    logic             mon_q;
    logic             rise;
    logic             fall;
    logic             bypass;
    logic             ratio_chg;
    logic [CNT_W-1:0] exp_even;
    logic [CNT_W-1:0] cnt_inc;

    mon_state_t       state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [CNT_W-1:0] wd_q, wd_d;
    logic [CNT_W-1:0] hi_cap_q, hi_cap_d;
    logic [CNT_W-1:0] period_q, period_d;
    logic [CNT_W-1:0] high_q, high_d;
    logic [WIDTH-1:0] ratio_q;
    logic             valid_q, valid_d;
    logic             mismatch_q, mismatch_d, mismatch_set;
    logic             stuck_q, stuck_d, stuck_set;

    sync_2ff #(
        .W (1)
    ) u_mon_sync (
        .clk   (REF_CLK),
        .rst_n (RST),
        .d     (MON_CLK),
        .q     (mon_sync)
    );

    assign rise      = mon_sync & ~mon_q;
    assign fall      = ~mon_sync & mon_q;
    assign bypass    = (EXP_RATIO[WIDTH-1:1] == '0);
    assign ratio_chg = (EXP_RATIO != ratio_q);
    assign exp_even  = CNT_W'(even_ratio(RATIO_MAX_W'(EXP_RATIO)));
    assign cnt_inc   = (cnt_q == CNT_MAX) ? cnt_q : cnt_q + ONE;

    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        wd_d         = wd_q;
        hi_cap_d     = hi_cap_q;
        period_d     = period_q;
        high_d       = high_q;
        valid_d      = 1'b0;
        mismatch_set = 1'b0;
        stuck_set    = 1'b0;

        if (!MEAS_EN || bypass) begin
            state_d = IDLE;
            cnt_d   = '0;
            wd_d    = '0;
        end else if (state_q != IDLE && ratio_chg) begin
            // Ratio reprogrammed mid-measurement: the partial count is meaningless.
            state_d = ARM;
            cnt_d   = '0;
            wd_d    = '0;
        end else begin
            unique case (state_q)
                IDLE: begin
                    state_d = ARM;
                    cnt_d   = '0;
                    wd_d    = '0;
                end
                ARM: begin
                    if (rise) begin
                        cnt_d   = ONE;
                        state_d = HIGH;
                    end
                end
                HIGH: begin
                    cnt_d = cnt_inc;
                    if (fall) begin
                        hi_cap_d = cnt_q;
                        state_d  = LOW;
                    end
                end
                LOW: begin
                    cnt_d = cnt_inc;
                    if (rise) begin
                        period_d     = cnt_q;
                        high_d       = hi_cap_q;
                        valid_d      = 1'b1;
                        mismatch_set = (cnt_q != exp_even);
                        cnt_d        = ONE;
                        state_d      = HIGH;
                    end
                end
                default: state_d = IDLE;
            endcase

            // Watchdog runs in every active state; a rise in the timeout cycle wins.
            if (state_q != IDLE) begin
                if (rise) begin
                    wd_d = ONE;
                end else if (wd_q >= TIMEOUT_C) begin
                    stuck_set = 1'b1;
                    state_d   = ARM;
                    cnt_d     = '0;
                    wd_d      = '0;
                end else begin
                    wd_d = wd_q + ONE;
                end
            end
        end

        mismatch_d = mismatch_set | (mismatch_q & ~CLR);
        stuck_d    = stuck_set | (stuck_q & ~CLR);
    end

    always_ff @(posedge REF_CLK or negedge RST) begin
        if (!RST) begin
            mon_q      <= 1'b0;
            state_q    <= IDLE;
            cnt_q      <= '0;
            wd_q       <= '0;
            hi_cap_q   <= '0;
            period_q   <= '0;
            high_q     <= '0;
            ratio_q    <= '0;
            valid_q    <= 1'b0;
            mismatch_q <= 1'b0;
            stuck_q    <= 1'b0;
        end else begin
            mon_q      <= mon_sync;
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            wd_q       <= wd_d;
            hi_cap_q   <= hi_cap_d;
            period_q   <= period_d;
            high_q     <= high_d;
            ratio_q    <= EXP_RATIO;
            valid_q    <= valid_d;
            mismatch_q <= mismatch_d;
            stuck_q    <= stuck_d;
        end
    end

    assign PERIOD     = period_q;
    assign HIGH_TIME  = high_q;
    assign MEAS_VALID = valid_q;
    assign MISMATCH   = mismatch_q;
    assign STUCK      = stuck_q;

endmodule

// File: tb/tb_clk_ratio_monitor.sv
// Scoreboard bench for clk_ratio_monitor: a behavioural divider drives MON_CLK,
// expected measurements are queued by the stimulus and popped on MEAS_VALID.
module tb_clk_ratio_monitor;

    localparam int WIDTH    = 6;
    localparam int CNT_W    = 8;
    localparam int TIMEOUT  = 200;
    localparam int SYNC_LAT = 3; // divider rise drive -> rise pulse processed by the FSM

    typedef struct {
        int period;
        int high;
        int mm;
        int st;
        int gap; // cycles since previous MEAS_VALID, 0 = unchecked
        int at;  // absolute cycle of MEAS_VALID, 0 = unchecked
    } exp_t;

    logic             ref_clk = 1'b0;
    logic             rst_n   = 1'b1;
    logic             mon_div = 1'b0;
    logic             bypass  = 1'b0;
    logic             hold    = 1'b0;
    logic             meas_en = 1'b0;
    logic             clr     = 1'b0;
    logic [WIDTH-1:0] exp_ratio = '0;
    logic             mon_clk;
    logic [CNT_W-1:0] period;
    logic [CNT_W-1:0] high_time;
    logic             meas_valid;
    logic             mismatch;
    logic             stuck;

    int   compared       = 0;
    int   mismatched     = 0;
    int   cycles         = 0;
    int   div_ratio      = 6;
    int   last_rise_cyc  = 0;
    int   last_valid_cyc = 0;
    exp_t sb[$];

    clk_ratio_monitor #(
        .WIDTH   (WIDTH),
        .CNT_W   (CNT_W),
        .TIMEOUT (TIMEOUT)
    ) dut (
        .REF_CLK    (ref_clk),
        .RST        (rst_n),
        .MON_CLK    (mon_clk),
        .EXP_RATIO  (exp_ratio),
        .MEAS_EN    (meas_en),
        .CLR        (clr),
        .PERIOD     (period),
        .HIGH_TIME  (high_time),
        .MEAS_VALID (meas_valid),
        .MISMATCH   (mismatch),
        .STUCK      (stuck)
    );

    always #5 ref_clk = ~ref_clk;
    always @(posedge ref_clk) cycles <= cycles + 1;
    assign mon_clk = bypass ? ref_clk : mon_div;

    // Divider model: odd ratios run as the next lower even ratio, 50% duty.
    initial begin : divider
        int div_cnt;
        int r;
        logic nxt;
        div_cnt = 0;
        forever begin
            @(posedge ref_clk);
            #1;
            r   = div_ratio & ~1;
            nxt = !hold && (div_cnt < r / 2);
            if (nxt && !mon_div) last_rise_cyc = cycles;
            mon_div = nxt;
            div_cnt = (div_cnt + 1 >= r) ? 0 : div_cnt + 1;
        end
    end

    task automatic check(input string name, input int act, input int exp);
        compared++;
        if (act != exp) begin
            mismatched++;
            $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cycles);
        end
    endtask

    initial begin : monitor
        exp_t e;
        forever begin
            @(negedge ref_clk);
            if (rst_n && meas_valid) begin
                if (sb.size() == 0) begin
                    check("unexpected_valid", int'(meas_valid), 0);
                end else begin
                    e = sb.pop_front();
                    check("period", int'(period), e.period);
                    check("high_time", int'(high_time), e.high);
                    check("mismatch_at_valid", int'(mismatch), e.mm);
                    check("stuck_at_valid", int'(stuck), e.st);
                    if (e.gap != 0) check("valid_gap", cycles - last_valid_cyc, e.gap);
                    if (e.at != 0) check("valid_cycle", cycles, e.at);
                end
                last_valid_cyc = cycles;
            end
        end
    end

    task automatic push(input int p, input int h, input int mm, input int st, input int gap,
                        input int at);
        exp_t e;
        e.period = p;
        e.high   = h;
        e.mm     = mm;
        e.st     = st;
        e.gap    = gap;
        e.at     = at;
        sb.push_back(e);
    endtask

    task automatic wait_size(input int n, input int budget);
        int k;
        k = 0;
        while (sb.size() > n && k < budget) begin
            @(posedge ref_clk);
            k++;
        end
        if (sb.size() > n) begin
            check("valid_timeout_pending", sb.size(), n);
            sb.delete();
        end
    endtask

    task automatic start_scn(input int er, input int dr);
        @(posedge ref_clk);
        #1;
        meas_en   = 1'b0;
        bypass    = 1'b0;
        hold      = 1'b0;
        div_ratio = dr;
        exp_ratio = WIDTH'(er);
        clr       = 1'b1;
        @(posedge ref_clk);
        #1;
        clr = 1'b0;
        repeat (20) @(posedge ref_clk);
        #1;
        meas_en = 1'b1;
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_period"}, int'(period), 0);
        check({tag, "_high_time"}, int'(high_time), 0);
        check({tag, "_meas_valid"}, int'(meas_valid), 0);
        check({tag, "_mismatch"}, int'(mismatch), 0);
        check({tag, "_stuck"}, int'(stuck), 0);
    endtask

    initial begin : stimulus
        int   target;
        int   rc0;
        int   k;
        logic prev;
        logic any_flag;

        #3 rst_n = 1'b0;
        #1 check_all_zero("reset");
        repeat (3) @(negedge ref_clk);
        rst_n = 1'b1;

        // Ratio 6 from the divider at ratio 6.
        start_scn(6, 6);
        push(6, 3, 0, 0, 0, 0);
        push(6, 3, 0, 0, 6, 0);
        push(6, 3, 0, 0, 6, 0);
        wait_size(0, 200);

        // Odd ratio 7 runs and checks as 6.
        start_scn(7, 7);
        push(6, 3, 0, 0, 0, 0);
        push(6, 3, 0, 0, 6, 0);
        push(6, 3, 0, 0, 6, 0);
        wait_size(0, 200);

        // Expect 6, divider at 8: mismatch, clear, re-set on the next period.
        start_scn(6, 8);
        push(8, 4, 1, 0, 0, 0);
        push(8, 4, 1, 0, 8, 0);
        wait_size(1, 200);
        #1 clr = 1'b1;
        @(posedge ref_clk);
        #1 clr = 1'b0;
        @(negedge ref_clk);
        check("mismatch_after_clr", int'(mismatch), 0);
        wait_size(0, 200);

        // MON_CLK stops: STUCK exactly TIMEOUT cycles after the last rise pulse.
        start_scn(6, 6);
        push(6, 3, 0, 0, 0, 0);
        push(6, 3, 0, 0, 6, 0);
        wait_size(0, 200);
        @(negedge ref_clk);
        hold   = 1'b1;
        target = last_rise_cyc + SYNC_LAT + TIMEOUT;
        while (cycles < target - 1) @(negedge ref_clk);
        check("stuck_before_timeout", int'(stuck), 0);
        @(negedge ref_clk);
        check("stuck_at_timeout", int'(stuck), 1);
        push(6, 3, 0, 1, 0, 0);
        hold = 1'b0;
        wait_size(0, 300);
        @(posedge ref_clk);
        #1 clr = 1'b1;
        @(posedge ref_clk);
        #1 clr = 1'b0;
        @(negedge ref_clk);
        check("stuck_after_clr", int'(stuck), 0);

        // Reset in the LOW state, released while MON_CLK is low.
        start_scn(6, 6);
        push(6, 3, 0, 0, 0, 0);
        wait_size(0, 200);
        repeat (3) @(posedge ref_clk);
        @(negedge ref_clk);
        rst_n = 1'b0;
        #1 check_all_zero("mid_reset");
        repeat (3) @(negedge ref_clk);
        prev = mon_div;
        k    = 0;
        do begin
            @(negedge ref_clk);
            k++;
            if (!mon_div && prev) break;
            prev = mon_div;
        end while (k < 50);
        rst_n = 1'b1;
        rc0   = last_rise_cyc;
        k     = 0;
        while (last_rise_cyc == rc0 && k < 50) begin
            @(posedge ref_clk);
            #2;
            k++;
        end
        push(6, 3, 0, 0, 0, last_rise_cyc + SYNC_LAT + 6);
        wait_size(0, 100);

        // Bypass: MON_CLK is REF_CLK, nothing may be measured or flagged.
        start_scn(1, 6);
        bypass   = 1'b1;
        any_flag = 1'b0;
        repeat (1000) begin
            @(negedge ref_clk);
            any_flag = any_flag | mismatch | stuck;
        end
        check("bypass_flags_seen", int'(any_flag), 0);
        check("bypass_mismatch", int'(mismatch), 0);
        check("bypass_stuck", int'(stuck), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
